// File: rtl/fade_sequencer.sv
// fade_sequencer: RGB colour-wheel fader. A prescaler paces ramp steps.
// Each of six colour phases ramps one channel up or down while the other
// two channels hold their levels. Each duty value drives a PWM output.
// Optional feature macro: FADE_SEQUENCER_PWM_EN. When it is defined, the
// PWM counter and the *_pwm outputs are built. When it is undefined, the
// *_pwm outputs are tied low.
module fade_sequencer #(
    parameter int STEP_INTERVAL   = 12000,
    parameter int STEPS_PER_PHASE = 200,
    parameter int PWM_INTERVAL    = 1200
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    output logic [$clog2(PWM_INTERVAL+1)-1:0]  red_value,
    output logic [$clog2(PWM_INTERVAL+1)-1:0]  green_value,
    output logic [$clog2(PWM_INTERVAL+1)-1:0]  blue_value,
    output logic                               red_pwm,
    output logic                               green_pwm,
    output logic                               blue_pwm,
    output logic [2:0]                         phase,
    output logic                               step_tick
);

    localparam int STEP_VAL = PWM_INTERVAL / STEPS_PER_PHASE;
    localparam int VW       = $clog2(PWM_INTERVAL + 1);
    localparam int PW       = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int SW       = $clog2(STEPS_PER_PHASE);

    localparam logic [VW-1:0] FULL       = VW'(PWM_INTERVAL);
    localparam logic [VW-1:0] STEP       = VW'(STEP_VAL);
    localparam logic [VW-1:0] RISE_LIMIT = VW'(PWM_INTERVAL - STEP_VAL);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_PHASE - 1);

    // Phase names give the moving channel and its direction.
    typedef enum logic [2:0] {
        PH_G_UP   = 3'd0,
        PH_R_DOWN = 3'd1,
        PH_B_UP   = 3'd2,
        PH_G_DOWN = 3'd3,
        PH_R_UP   = 3'd4,
        PH_B_DOWN = 3'd5
    } phase_e;

    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_step_cnt;
    phase_e        r_phase;
    logic [VW-1:0] r_red, r_green, r_blue;
    logic          r_step_tick;

    logic          w_step;
    logic          w_last;
    logic [PW-1:0] w_presc_nxt;
    logic [SW-1:0] w_step_cnt_nxt;
    phase_e        w_phase_nxt;
    logic [VW-1:0] w_red_nxt, w_green_nxt, w_blue_nxt;

    // Add one step to a rising value. Clamp at full scale, never wrap.
    function automatic logic [VW-1:0] ramp_up(input logic [VW-1:0] v);
        return (v >= RISE_LIMIT) ? FULL : v + STEP;
    endfunction

    // Subtract one step from a falling value. Clamp at zero, never wrap.
    function automatic logic [VW-1:0] ramp_down(input logic [VW-1:0] v);
        return (v <= STEP) ? '0 : v - STEP;
    endfunction

    // Next-state logic: prescaler, step counter, phase and the moving channel.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        w_step         = enable && (r_presc == PRESC_LAST);
        w_last         = 1'b0;
        w_presc_nxt    = r_presc;
        w_step_cnt_nxt = r_step_cnt;
        w_phase_nxt    = r_phase;
        w_red_nxt      = r_red;
        w_green_nxt    = r_green;
        w_blue_nxt     = r_blue;

        if (enable) begin
            w_presc_nxt = w_step ? '0 : r_presc + 1'b1;
        end

        if (w_step) begin
            w_last         = (r_step_cnt == STEP_LAST);
            w_step_cnt_nxt = w_last ? '0 : r_step_cnt + 1'b1;
            case (r_phase)
                PH_G_UP:   w_green_nxt = w_last ? FULL : ramp_up(r_green);
                PH_R_DOWN: w_red_nxt   = w_last ? '0   : ramp_down(r_red);
                PH_B_UP:   w_blue_nxt  = w_last ? FULL : ramp_up(r_blue);
                PH_G_DOWN: w_green_nxt = w_last ? '0   : ramp_down(r_green);
                PH_R_UP:   w_red_nxt   = w_last ? FULL : ramp_up(r_red);
                PH_B_DOWN: w_blue_nxt  = w_last ? '0   : ramp_down(r_blue);
                default:   w_phase_nxt = PH_G_UP;
            endcase
            if (w_last) begin
                w_phase_nxt = (r_phase == PH_B_DOWN) ? PH_G_UP : phase_e'(r_phase + 3'd1);
            end
        end
    end

    // Sequencer state register. Reset takes priority over enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so each register samples pre-edge values.
        if (rst) begin
            r_presc     <= '0;
            r_step_cnt  <= '0;
            r_phase     <= PH_G_UP;
            r_red       <= FULL;
            r_green     <= '0;
            r_blue      <= '0;
            r_step_tick <= 1'b0;
        end else begin
            r_presc     <= w_presc_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_red       <= w_red_nxt;
            r_green     <= w_green_nxt;
            r_blue      <= w_blue_nxt;
            r_step_tick <= w_step;
        end
    end

    assign red_value   = r_red;
    assign green_value = r_green;
    assign blue_value  = r_blue;
    assign phase       = r_phase;
    assign step_tick   = r_step_tick;

`ifdef FADE_SEQUENCER_PWM_EN
    localparam logic [VW-1:0] PWM_LAST = VW'(PWM_INTERVAL - 1);

    logic [VW-1:0] r_pwm_cnt;
    logic          r_red_pwm, r_green_pwm, r_blue_pwm;

    // Free-running PWM counter with registered compares. A duty change
    // takes effect at the next compare and does not restart the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt   <= '0;
            r_red_pwm   <= 1'b0;
            r_green_pwm <= 1'b0;
            r_blue_pwm  <= 1'b0;
        end else begin
            r_pwm_cnt   <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
            r_red_pwm   <= (r_pwm_cnt < r_red);
            r_green_pwm <= (r_pwm_cnt < r_green);
            r_blue_pwm  <= (r_pwm_cnt < r_blue);
        end
    end

    assign red_pwm   = r_red_pwm;
    assign green_pwm = r_green_pwm;
    assign blue_pwm  = r_blue_pwm;
`else
    assign red_pwm   = 1'b0;
    assign green_pwm = 1'b0;
    assign blue_pwm  = 1'b0;
`endif

endmodule

// File: tb/tb_fade_sequencer.sv
// tb_fade_sequencer: directed, table-driven bench for fade_sequencer.
// Main DUT: STEP_INTERVAL=4, STEPS_PER_PHASE=4, PWM_INTERVAL=8.
// Side DUT: PWM_INTERVAL=10.
// The PWM expectations follow the FADE_SEQUENCER_PWM_EN macro.
module tb_fade_sequencer;

`ifdef FADE_SEQUENCER_PWM_EN
    localparam logic PWM_ON = 1'b1;
`else
    localparam logic PWM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] red_value, green_value, blue_value;
    logic       red_pwm, green_pwm, blue_pwm;
    logic [2:0] phase;
    logic       step_tick;

    logic [3:0] r10, g10, b10;
    logic       rp10, gp10, bp10;
    logic [2:0] ph10;
    logic       tk10;

    int checks   = 0;
    int failures = 0;

    fade_sequencer #(.STEP_INTERVAL(4), .STEPS_PER_PHASE(4), .PWM_INTERVAL(8)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .red_value(red_value), .green_value(green_value), .blue_value(blue_value),
        .red_pwm(red_pwm), .green_pwm(green_pwm), .blue_pwm(blue_pwm),
        .phase(phase), .step_tick(step_tick)
    );

    fade_sequencer #(.STEP_INTERVAL(4), .STEPS_PER_PHASE(4), .PWM_INTERVAL(10)) dut10 (
        .clk(clk), .rst(rst), .enable(enable),
        .red_value(r10), .green_value(g10), .blue_value(b10),
        .red_pwm(rp10), .green_pwm(gp10), .blue_pwm(bp10),
        .phase(ph10), .step_tick(tk10)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        int   n;
        int   r;
        int   g;
        int   b;
        int   ph;
        logic tick_end;
    } vec_t;

    vec_t tbl[24];
    int   g10_exp[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge, then settle 1 time unit past it for sampling and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
    endtask

    task automatic run(input logic en, input int n);
        enable = en;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pr, pg, pb, d, cnt_g, cnt_r, cnt_b;

        // Full 96-edge traversal, one record per step (4 enabled edges).
        tbl[0]  = '{1'b1, 4, 8, 2, 0, 0, 1'b1};
        tbl[1]  = '{1'b1, 4, 8, 4, 0, 0, 1'b1};
        tbl[2]  = '{1'b1, 4, 8, 6, 0, 0, 1'b1};
        tbl[3]  = '{1'b1, 4, 8, 8, 0, 1, 1'b1};
        tbl[4]  = '{1'b1, 4, 6, 8, 0, 1, 1'b1};
        tbl[5]  = '{1'b1, 4, 4, 8, 0, 1, 1'b1};
        tbl[6]  = '{1'b1, 4, 2, 8, 0, 1, 1'b1};
        tbl[7]  = '{1'b1, 4, 0, 8, 0, 2, 1'b1};
        tbl[8]  = '{1'b1, 4, 0, 8, 2, 2, 1'b1};
        tbl[9]  = '{1'b1, 4, 0, 8, 4, 2, 1'b1};
        tbl[10] = '{1'b1, 4, 0, 8, 6, 2, 1'b1};
        tbl[11] = '{1'b1, 4, 0, 8, 8, 3, 1'b1};
        tbl[12] = '{1'b1, 4, 0, 6, 8, 3, 1'b1};
        tbl[13] = '{1'b1, 4, 0, 4, 8, 3, 1'b1};
        tbl[14] = '{1'b1, 4, 0, 2, 8, 3, 1'b1};
        tbl[15] = '{1'b1, 4, 0, 0, 8, 4, 1'b1};
        tbl[16] = '{1'b1, 4, 2, 0, 8, 4, 1'b1};
        tbl[17] = '{1'b1, 4, 4, 0, 8, 4, 1'b1};
        tbl[18] = '{1'b1, 4, 6, 0, 8, 4, 1'b1};
        tbl[19] = '{1'b1, 4, 8, 0, 8, 5, 1'b1};
        tbl[20] = '{1'b1, 4, 8, 0, 6, 5, 1'b1};
        tbl[21] = '{1'b1, 4, 8, 0, 4, 5, 1'b1};
        tbl[22] = '{1'b1, 4, 8, 0, 2, 5, 1'b1};
        tbl[23] = '{1'b1, 4, 8, 0, 0, 0, 1'b1};
        g10_exp = '{2, 4, 6, 10};

        // Reset state.
        do_reset();
        check("rst_red",   red_value,   8);
        check("rst_green", green_value, 0);
        check("rst_blue",  blue_value,  0);
        check("rst_phase", phase,       0);
        check("rst_tick",  step_tick,   0);
        check("rst_rpwm",  red_pwm,     0);
        check("rst_gpwm",  green_pwm,   0);
        check("rst_bpwm",  blue_pwm,    0);
        check("rst_red10", r10,         10);

        // Table-driven traversal of all six phases.
        pr = 8; pg = 0; pb = 0;
        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                enable = tbl[i].en;
                tick();
                check($sformatf("tick_v%0d_e%0d", i, j), step_tick,
                      (j == tbl[i].n - 1) ? tbl[i].tick_end : 1'b0);
                d = int'(red_value) - pr;
                check("red_delta",   (d >= -2 && d <= 2 && red_value <= 8), 1);
                d = int'(green_value) - pg;
                check("green_delta", (d >= -2 && d <= 2 && green_value <= 8), 1);
                d = int'(blue_value) - pb;
                check("blue_delta",  (d >= -2 && d <= 2 && blue_value <= 8), 1);
                pr = red_value; pg = green_value; pb = blue_value;
            end
            check($sformatf("red_v%0d", i),   red_value,   tbl[i].r);
            check($sformatf("green_v%0d", i), green_value, tbl[i].g);
            check($sformatf("blue_v%0d", i),  blue_value,  tbl[i].b);
            check($sformatf("phase_v%0d", i), phase,       tbl[i].ph);
            if (i < 4) begin
                check($sformatf("green10_v%0d", i), g10, g10_exp[i]);
                check($sformatf("phase10_v%0d", i), ph10, (i == 3) ? 1 : 0);
            end
        end

        // PWM at red=8, green=2, blue=0 while the sequence is frozen.
        do_reset();
        run(1'b1, 4);
        check("pwm_setup_green", green_value, 2);
        run(1'b0, 1);
        cnt_r = 0; cnt_g = 0; cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            cnt_r += int'(red_pwm);
            cnt_g += int'(green_pwm);
            cnt_b += int'(blue_pwm);
        end
        check("red_pwm_high16",   cnt_r, PWM_ON ? 16 : 0);
        check("green_pwm_high16", cnt_g, PWM_ON ? 4  : 0);
        check("blue_pwm_high16",  cnt_b, 0);

        // Freeze at green=4 for 20 cycles, then resume: step after 4 enabled edges.
        run(1'b1, 4);
        check("frz_setup_green", green_value, 4);
        check("frz_setup_tick",  step_tick,   1);
        for (int i = 0; i < 20; i++) begin
            enable = 1'b0;
            tick();
            check("frz_green", green_value, 4);
            check("frz_phase", phase,       0);
            check("frz_tick",  step_tick,   0);
        end
        for (int i = 0; i < 4; i++) begin
            enable = 1'b1;
            tick();
            check($sformatf("resume_tick_e%0d", i), step_tick, (i == 3) ? 1 : 0);
            check($sformatf("resume_green_e%0d", i), green_value, (i == 3) ? 6 : 4);
        end

        // Reset at phase 3 step 2, on an edge that would otherwise apply a step.
        do_reset();
        run(1'b1, 59);
        check("pre_rst_phase", phase,       3);
        check("pre_rst_green", green_value, 4);
        rst    = 1'b1;
        enable = 1'b1;
        tick();
        rst    = 1'b0;
        check("midrst_phase", phase,       0);
        check("midrst_red",   red_value,   8);
        check("midrst_green", green_value, 0);
        check("midrst_blue",  blue_value,  0);
        check("midrst_tick",  step_tick,   0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("restart_tick_e%0d", i), step_tick, (i == 3) ? 1 : 0);
        end
        check("restart_green", green_value, 2);
        check("restart_phase", phase,       0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
